// File: rtl/hpc3_rand_pkg.sv
// -----------------------------------------------------------------------------
// hpc3_rand_pkg
//
// Shared definitions for the HPC3 GF(4) fresh-randomness source:
//   - 128-bit LFSR geometry and feedback tap positions
//   - number of 32-bit seed words that make up one full LFSR state
//   - FSM state encoding of the generator
//   - calc_zw(): width of one Z (or R) vector for a given share count
// -----------------------------------------------------------------------------
package hpc3_rand_pkg;

    localparam int unsigned STATE_W    = 128;
    localparam int unsigned SEED_WORDS = 4;

    // Feedback taps of the 128-bit Fibonacci LFSR (bit indices of S).
    localparam int unsigned TAP0 = 127;
    localparam int unsigned TAP1 = 125;
    localparam int unsigned TAP2 = 100;
    localparam int unsigned TAP3 = 98;

    // FAULT is only ever entered when the health monitor is built in.
    typedef enum logic [1:0] {
        SEED   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FAULT  = 2'd3
    } rand_state_e;

    // Z (and R) width consumed per cycle by the shared multipliers.
    function automatic int unsigned calc_zw(input int unsigned shares);
        return 2 * shares * (shares - 1);
    endfunction

endpackage

// File: rtl/lfsr128_adv.sv
// -----------------------------------------------------------------------------
// lfsr128_adv
//
// Purely combinational multi-step advance of the 128-bit LFSR.
// One single step is:  fb = S[127]^S[125]^S[100]^S[98];  S = {S[126:0], fb}
// and this block applies STEPS of them back to back.
//
// Parameters:
//   STEPS     number of single LFSR steps unrolled into one advance
//
// Ports:
//   StatexDI  in  128  LFSR state before the advance
//   StatexDO  out 128  LFSR state after STEPS single steps
// -----------------------------------------------------------------------------
module lfsr128_adv
    import hpc3_rand_pkg::*;
#(
    parameter int unsigned STEPS = 96
) (
    input  logic [STATE_W-1:0] StatexDI,
    output logic [STATE_W-1:0] StatexDO
);

    logic [STATE_W-1:0] stepState;
    logic               fb;

    always_comb begin
        stepState = StatexDI;
        fb        = 1'b0;
        for (int unsigned i = 0; i < STEPS; i++) begin
            fb        = stepState[TAP0] ^ stepState[TAP1] ^ stepState[TAP2] ^ stepState[TAP3];
            stepState = {stepState[STATE_W-2:0], fb};
        end
        StatexDO = stepState;
    end

endmodule

// File: rtl/hpc3_gf4_rand_source.sv
// -----------------------------------------------------------------------------
// hpc3_gf4_rand_source
//
// Fresh-randomness producer for the shared HPC3 GF(4) square-scale multipliers
// of the masked AES S-box. A 128-bit LFSR, seeded by the host with four 32-bit
// words, is advanced by RAND_W steps per produced word; the low RAND_W bits of
// the advanced state form one word W, split into Z (low half) and R (high half).
// Words leave through a valid/ready handshake: each word is presented until it
// is accepted, exactly once, and the next word is loaded on the accepting edge.
//
// Parameters:
//   SHARES       number of masking shares (2..6); ZW = 2*SHARES*(SHARES-1)
//   WARMUP_ADV   advances discarded after seeding (0..255)
//
// Ports:
//   ClkxCI        in   1   clock, rising edge
//   RstxBI        in   1   asynchronous active-low reset
//   SeedValidxSI  in   1   seed word strobe (only honoured in SEED)
//   SeedxDI       in  32   seed word, k-th strobe fills S[32k+31:32k]
//   ReseedxSI     in   1   reseed request, wins over everything but reset
//   _ZxDO         out ZW   blinding randomness (multiplier Z input)
//   _RxDO         out ZW   refresh randomness (multiplier R input)
//   ValidxSO      out  1   Z/R word valid
//   ReadyxSI      in   1   consumer accepts the current word
//   SeededxSO     out  1   generator is in RUN
//   ErrorxSO      out  1   sticky health fault (0 unless monitor built in)
//
// Build option:
//   HPC3_RAND_HEALTH_EN  adds a repetition / all-zero monitor on every newly
//                        loaded word and the FAULT state; left undefined,
//                        ErrorxSO is tied low and FAULT is unreachable.
// -----------------------------------------------------------------------------
module hpc3_gf4_rand_source
    import hpc3_rand_pkg::*;
#(
    parameter int unsigned SHARES     = 4,
    parameter int unsigned WARMUP_ADV = 4
) (
    input  logic                         ClkxCI,
    input  logic                         RstxBI,
    input  logic                         SeedValidxSI,
    input  logic [31:0]                  SeedxDI,
    input  logic                         ReseedxSI,
    output logic [calc_zw(SHARES)-1:0]   _ZxDO,
    output logic [calc_zw(SHARES)-1:0]   _RxDO,
    output logic                         ValidxSO,
    input  logic                         ReadyxSI,
    output logic                         SeededxSO,
    output logic                         ErrorxSO
);

    localparam int unsigned ZW     = calc_zw(SHARES);
    localparam int unsigned RAND_W = 2 * ZW;
    localparam int unsigned IDX_W  = $clog2(SEED_WORDS);

    generate
        if ((RAND_W > STATE_W) || (SHARES < 2) || (WARMUP_ADV > 255)) begin : gBadParams
            $error("hpc3_gf4_rand_source: unsupported SHARES/WARMUP_ADV (RAND_W must be <= 128)");
        end
    endgenerate

    rand_state_e         fsmQ, fsmD;
    logic [STATE_W-1:0]  stateQ, stateD;
    logic [STATE_W-1:0]  advOut;
    logic [STATE_W-1:0]  seedMerged;
    logic [IDX_W-1:0]    idxQ, idxD;
    logic [7:0]          cntQ, cntD;
    logic [ZW-1:0]       zQ, zD;
    logic [ZW-1:0]       rQ, rD;
    logic                validQ, validD;
    logic                seededQ, seededD;
    logic [RAND_W-1:0]   wordNew;
    logic                wordLoad;
    logic                loadOk;

    // Single advancer, always fed from the current state: WARMUP and RUN
    // never need an advance in the same cycle, so one instance suffices.
    lfsr128_adv #(
        .STEPS (RAND_W)
    ) uAdv (
        .StatexDI (stateQ),
        .StatexDO (advOut)
    );

    assign wordNew = advOut[RAND_W-1:0];

    // Current state with the incoming seed word dropped into slot idxQ.
    always_comb begin
        seedMerged = stateQ;
        seedMerged[{idxQ, 5'd0} +: 32] = SeedxDI;
    end

`ifdef HPC3_RAND_HEALTH_EN
    logic errQ, errD;
    logic repFault;

    // Output registers always hold the previously loaded word (or zero right
    // after seeding, in which case the equality test coincides with the
    // all-zero test), so no separate history register is needed.
    assign repFault = (wordNew == '0) || (wordNew == {rQ, zQ});
    assign loadOk   = ~repFault;
    assign ErrorxSO = errQ;
`else
    assign loadOk   = 1'b1;
    assign ErrorxSO = 1'b0;
`endif

    always_comb begin
        fsmD     = fsmQ;
        stateD   = stateQ;
        idxD     = idxQ;
        cntD     = cntQ;
        zD       = zQ;
        rD       = rQ;
        validD   = validQ;
        seededD  = seededQ;
        wordLoad = 1'b0;
`ifdef HPC3_RAND_HEALTH_EN
        errD     = errQ;
`endif

        if (ReseedxSI) begin
            // Reseed dominates any simultaneous seed strobe or handshake.
            fsmD    = SEED;
            idxD    = '0;
            zD      = '0;
            rD      = '0;
            validD  = 1'b0;
            seededD = 1'b0;
`ifdef HPC3_RAND_HEALTH_EN
            errD    = 1'b0;
`endif
        end else begin
            case (fsmQ)
                SEED: begin
                    if (SeedValidxSI) begin
                        stateD = seedMerged;
                        idxD   = idxQ + IDX_W'(1);
                        if (idxQ == IDX_W'(SEED_WORDS - 1)) begin
                            // The all-zero state is the LFSR's lock-up point.
                            if (seedMerged == '0) begin
                                stateD = {{(STATE_W-1){1'b0}}, 1'b1};
                            end
                            fsmD = WARMUP;
                            cntD = '0;
                        end
                    end
                end

                // With WARMUP_ADV = 0 this state lasts a single cycle and only
                // performs the advance that produces the first word.
                WARMUP: begin
                    stateD = advOut;
                    if (cntQ == 8'(WARMUP_ADV)) begin
                        wordLoad = 1'b1;
                    end else begin
                        cntD = cntQ + 8'd1;
                    end
                end

                RUN: begin
                    if (validQ && ReadyxSI) begin
                        stateD   = advOut;
                        wordLoad = 1'b1;
                    end
                end

                // FAULT: hold everything until reseed or reset.
                default: ;
            endcase

            if (wordLoad) begin
                if (loadOk) begin
                    zD      = wordNew[ZW-1:0];
                    rD      = wordNew[RAND_W-1:ZW];
                    validD  = 1'b1;
                    seededD = 1'b1;
                    fsmD    = RUN;
                end else begin
                    validD  = 1'b0;
                    seededD = 1'b0;
                    fsmD    = FAULT;
`ifdef HPC3_RAND_HEALTH_EN
                    errD    = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            fsmQ    <= SEED;
            stateQ  <= '0;
            idxQ    <= '0;
            cntQ    <= '0;
            zQ      <= '0;
            rQ      <= '0;
            validQ  <= 1'b0;
            seededQ <= 1'b0;
        end else begin
            fsmQ    <= fsmD;
            stateQ  <= stateD;
            idxQ    <= idxD;
            cntQ    <= cntD;
            zQ      <= zD;
            rQ      <= rD;
            validQ  <= validD;
            seededQ <= seededD;
        end
    end

`ifdef HPC3_RAND_HEALTH_EN
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            errQ <= 1'b0;
        end else begin
            errQ <= errD;
        end
    end
`endif

    assign _ZxDO     = zQ;
    assign _RxDO     = rQ;
    assign ValidxSO  = validQ;
    assign SeededxSO = seededQ;

endmodule
